adder_share_ctrl: RTL and testbench

//   Arbitrates N requesters onto one shared external adder_8bit and sequences

---
 rtl/adder_share_ctrl_if.sv | 45 ++++
 rtl/adder_share_ctrl.sv | 132 +++++++++++++
 tb/tb_adder_share_ctrl.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/adder_share_ctrl_if.sv
// Client/adder bundle for adder_share_ctrl: requests, operands, grant/result and the shared 8-bit adder pins.
// The ovf signal exists only when ADD_OVF_EN is defined.
interface adder_share_ctrl_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 32
);
  localparam int IDW = $clog2(N_REQ);

  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] a_flat;
  logic [N_REQ*WIDTH-1:0] b_flat;
  logic [N_REQ-1:0]       cin_vec;
  logic [N_REQ-1:0]       gnt;
  logic                   busy;
  logic                   done;
  logic [IDW-1:0]         done_id;
  logic [WIDTH-1:0]       result;
  logic                   cout;
  logic [7:0]             add_a;
  logic [7:0]             add_b;
  logic                   add_cin;
  logic [7:0]             add_sum;
  logic                   add_cout;
`ifdef ADD_OVF_EN
  logic                   ovf;

  modport master (
    output req, a_flat, b_flat, cin_vec, add_sum, add_cout,
    input  gnt, busy, done, done_id, result, cout, add_a, add_b, add_cin, ovf
  );
  modport slave (
    input  req, a_flat, b_flat, cin_vec, add_sum, add_cout,
    output gnt, busy, done, done_id, result, cout, add_a, add_b, add_cin, ovf
  );
`else
  modport master (
    output req, a_flat, b_flat, cin_vec, add_sum, add_cout,
    input  gnt, busy, done, done_id, result, cout, add_a, add_b, add_cin
  );
  modport slave (
    input  req, a_flat, b_flat, cin_vec, add_sum, add_cout,
    output gnt, busy, done, done_id, result, cout, add_a, add_b, add_cin
  );
`endif
endinterface

// File: rtl/adder_share_ctrl.sv
// Round-robin share of one 8-bit adder among N_REQ clients; WIDTH-bit sums sequenced a byte per cycle.
// Latency: grant edge, WIDTH/8 RUN cycles, one DONE cycle (done pulse); one op per WIDTH/8+2 cycles.
// No backpressure: clients hold req until granted; result is held until the next done. ADD_OVF_EN adds ovf.
module adder_share_ctrl #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 32
) (
  input logic               clk,
  input logic               rst,
  adder_share_ctrl_if.slave bus
);
  localparam int NSLICE = WIDTH / 8;
  localparam int IDW    = $clog2(N_REQ);
  localparam int SW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [IDW-1:0]   ptr, win, pick, done_id_q;
  logic             found;
  logic [SW-1:0]    slice;
  logic             last;
  logic [WIDTH-1:0] a_reg, b_reg, res_reg, res_nxt, result_q;
  logic             carry_reg, cout_q;
  logic [N_REQ-1:0] gnt_q;
  logic [7:0]       a_sl, b_sl;

  // First requester at or above ptr, wrapping.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && bus.req[(int'(ptr) + i) % N_REQ]) begin
        found = 1'b1;
        pick  = IDW'((int'(ptr) + i) % N_REQ);
      end
    end
  end

  always_comb begin
    a_sl    = '0;
    b_sl    = '0;
    res_nxt = res_reg;
    for (int s = 0; s < NSLICE; s++) begin
      if (slice == SW'(s)) begin
        a_sl              = a_reg[s*8 +: 8];
        b_sl              = b_reg[s*8 +: 8];
        res_nxt[s*8 +: 8] = bus.add_sum;
      end
    end
    last = (slice == SW'(NSLICE - 1));
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (found) state_nxt = RUN;
      RUN:     if (last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      win       <= '0;
      slice     <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      res_reg   <= '0;
      carry_reg <= 1'b0;
      gnt_q     <= '0;
      result_q  <= '0;
      cout_q    <= 1'b0;
      done_id_q <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (found) begin
            a_reg     <= bus.a_flat[int'(pick)*WIDTH +: WIDTH];
            b_reg     <= bus.b_flat[int'(pick)*WIDTH +: WIDTH];
            carry_reg <= bus.cin_vec[pick];
            gnt_q     <= N_REQ'(1) << pick;
            slice     <= '0;
            win       <= pick;
            ptr       <= IDW'((int'(pick) + 1) % N_REQ);
          end
        end
        RUN: begin
          res_reg   <= res_nxt;
          carry_reg <= bus.add_cout;
          slice     <= slice + SW'(1);
          // Publish on the last slice edge so outputs are stable for the whole DONE cycle.
          if (last) begin
            result_q  <= res_nxt;
            cout_q    <= bus.add_cout;
            done_id_q <= win;
          end
        end
        DONE:    gnt_q <= '0;
        default: gnt_q <= '0;
      endcase
    end
  end

`ifdef ADD_OVF_EN
  logic ovf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (state == RUN && last) begin
      ovf_q <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) && (res_nxt[WIDTH-1] != a_reg[WIDTH-1]);
    end
  end

  assign bus.ovf = ovf_q;
`endif

  assign bus.gnt     = gnt_q;
  assign bus.busy    = (state != IDLE);
  assign bus.done    = (state == DONE);
  assign bus.done_id = done_id_q;
  assign bus.result  = result_q;
  assign bus.cout    = cout_q;
  assign bus.add_a   = (state == RUN) ? a_sl : 8'h00;
  assign bus.add_b   = (state == RUN) ? b_sl : 8'h00;
  assign bus.add_cin = (state == RUN) ? carry_reg : 1'b0;
endmodule

// File: tb/tb_adder_share_ctrl.sv
// Scoreboard bench for adder_share_ctrl: a 4x32 instance and a 2x8 instance, each with a modelled 8-bit adder.
module tb_adder_share_ctrl;
  typedef struct {
    int          id;
    logic [31:0] res;
    logic        co;
    logic        ov;
    int          gap;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc;
  int   checks;
  int   errors;
  int   last_done;
  exp_t q[$];
  exp_t q8[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  adder_share_ctrl_if #(.N_REQ(4), .WIDTH(32)) bif ();
  adder_share_ctrl_if #(.N_REQ(2), .WIDTH(8))  b8 ();

  adder_share_ctrl #(.N_REQ(4), .WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bif.slave));
  adder_share_ctrl #(.N_REQ(2), .WIDTH(8))  dut8 (.clk(clk), .rst(rst), .bus(b8.slave));

  assign {bif.add_cout, bif.add_sum} = 9'(bif.add_a) + 9'(bif.add_b) + 9'(bif.add_cin);
  assign {b8.add_cout, b8.add_sum}   = 9'(b8.add_a) + 9'(b8.add_b) + 9'(b8.add_cin);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input int id, input logic [31:0] res, input logic co, input logic ov, input int gap);
    exp_t e;
    e.id = id; e.res = res; e.co = co; e.ov = ov; e.gap = gap;
    q.push_back(e);
  endtask

  task automatic set_op(input int id, input logic [31:0] a, input logic [31:0] b, input logic cin);
    bif.a_flat[id*32 +: 32] = a;
    bif.b_flat[id*32 +: 32] = b;
    bif.cin_vec[id]         = cin;
  endtask

  task automatic wait_gnt(input logic [3:0] exp_gnt, input string name);
    int n = 0;
    @(negedge clk);
    while (bif.gnt == 4'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk(name, bif.gnt, exp_gnt);
  endtask

  task automatic wait_idle(output int nbusy);
    nbusy = 0;
    while (bif.busy && nbusy < 100) begin
      @(negedge clk);
      nbusy++;
    end
  endtask

  // Main instance monitor: pops on every done.
  always @(negedge clk) begin
    if (!rst && bif.done) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got id %0d result %0h expected no done", bif.done_id, bif.result);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("done_id", 64'(bif.done_id), 64'(e.id));
        chk("result", bif.result, e.res);
        chk("cout", bif.cout, e.co);
`ifdef ADD_OVF_EN
        chk("ovf", bif.ovf, e.ov);
`endif
        if (e.gap >= 0) chk("done_gap", 64'(cyc - last_done), 64'(e.gap));
      end
      last_done = cyc;
    end
  end

  always @(negedge clk) begin
    if (!rst && b8.done) begin
      if (q8.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done8: got id %0d result %0h expected no done", b8.done_id, b8.result);
      end else begin
        exp_t e;
        e = q8.pop_front();
        chk("w8_done_id", 64'(b8.done_id), 64'(e.id));
        chk("w8_result", 64'(b8.result), 64'(e.res[7:0]));
        chk("w8_cout", b8.cout, e.co);
`ifdef ADD_OVF_EN
        chk("w8_ovf", b8.ovf, e.ov);
`endif
      end
    end
  end

  initial begin
    int nb;
    int n;
    bif.req = '0; bif.a_flat = '0; bif.b_flat = '0; bif.cin_vec = '0;
    b8.req  = '0; b8.a_flat  = '0; b8.b_flat  = '0; b8.cin_vec  = '0;

    // Reset state
    @(negedge clk);
    chk("rst_gnt", bif.gnt, 0);
    chk("rst_busy", bif.busy, 0);
    chk("rst_done", bif.done, 0);
    chk("rst_result", bif.result, 0);
    chk("rst_cout", bif.cout, 0);
    chk("rst_done_id", 64'(bif.done_id), 0);
    chk("rst_add_a", bif.add_a, 0);
    chk("rst_add_cin", bif.add_cin, 0);
    @(negedge clk);
    rst = 1'b0;

    // Wrap-around: FFFFFFFF + 1
    set_op(0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    bif.req = 4'b0001;
    push(0, 32'h0000_0000, 1'b1, 1'b0, -1);
    wait_gnt(4'b0001, "t1_gnt");
    chk("t1_add_a", bif.add_a, 8'hFF);
    chk("t1_add_b", bif.add_b, 8'h01);
    bif.req = 4'b0;
    wait_idle(nb);
    chk("t1_busy_cycles", 64'(nb), 5);
    chk("t1_idle_add_a", bif.add_a, 0);

    // Carry-in, mixed bytes
    set_op(2, 32'h1234_5678, 32'h0F0F_0F0F, 1'b1);
    bif.req = 4'b0100;
    push(2, 32'h2143_6588, 1'b0, 1'b0, -1);
    wait_gnt(4'b0100, "t3_gnt");
    chk("t3_add_cin", bif.add_cin, 1'b1);
    bif.req = 4'b0;
    wait_idle(nb);

    // Operands changed after grant have no effect
    set_op(1, 32'h0000_0010, 32'h0000_0020, 1'b0);
    bif.req = 4'b0010;
    push(1, 32'h0000_0030, 1'b0, 1'b0, -1);
    wait_gnt(4'b0010, "t6_gnt");
    set_op(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    bif.req = 4'b0;
    wait_idle(nb);

    // Signed overflow case, leaves ptr back at 0
    set_op(3, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    bif.req = 4'b1000;
    push(3, 32'h8000_0000, 1'b0, 1'b1, -1);
    wait_gnt(4'b1000, "t6b_gnt");
    bif.req = 4'b0;
    wait_idle(nb);

    // All requesting: round-robin 0,1,2,3,0 every 6 cycles
    for (int i = 0; i < 4; i++) set_op(i, 32'(i), 32'h0000_0100, 1'b0);
    push(0, 32'h0000_0100, 1'b0, 1'b0, -1);
    push(1, 32'h0000_0101, 1'b0, 1'b0, 6);
    push(2, 32'h0000_0102, 1'b0, 1'b0, 6);
    push(3, 32'h0000_0103, 1'b0, 1'b0, 6);
    push(0, 32'h0000_0100, 1'b0, 1'b0, 6);
    bif.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_gnt(4'(1 << (k % 4)), "rr_gnt");
      if (k == 4) bif.req = 4'b0;
      n = 0;
      while (bif.gnt != 4'b0 && n < 50) begin
        @(negedge clk);
        n++;
      end
    end

    // Reset in the second RUN cycle
    set_op(0, 32'h0000_0005, 32'h0000_0006, 1'b0);
    bif.req = 4'b0001;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    bif.req = 4'b0;
    #1;
    chk("t5_gnt", bif.gnt, 0);
    chk("t5_busy", bif.busy, 0);
    chk("t5_result", bif.result, 0);
    chk("t5_add_a", bif.add_a, 0);
    @(negedge clk);
    rst = 1'b0;
    set_op(3, 32'h0000_0001, 32'h0000_0002, 1'b0);
    bif.req = 4'b1000;
    push(3, 32'h0000_0003, 1'b0, 1'b0, -1);
    wait_gnt(4'b1000, "t5_regrant");
    bif.req = 4'b0;
    wait_idle(nb);

    // WIDTH=8 instance
    b8.a_flat = 16'h0180;
    b8.b_flat = 16'hFE80;
    b8.cin_vec = 2'b10;
    q8.push_back('{id: 0, res: 32'h00, co: 1'b1, ov: 1'b1, gap: -1});
    q8.push_back('{id: 1, res: 32'h00, co: 1'b1, ov: 1'b0, gap: -1});
    b8.req = 2'b01;
    @(negedge clk);
    chk("w8_gnt", b8.gnt, 2'b01);
    b8.req = 2'b00;
    nb = 0;
    while (b8.busy && nb < 100) begin
      @(negedge clk);
      nb++;
    end
    chk("w8_busy_cycles", 64'(nb), 2);
    b8.req = 2'b10;
    @(negedge clk);
    chk("w8_gnt2", b8.gnt, 2'b10);
    b8.req = 2'b00;
    repeat (6) @(negedge clk);

    chk("sb_empty", 64'(q.size()), 0);
    chk("sb8_empty", 64'(q8.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
